adder: RTL and testbench

// - Registered ripple-carry adder: sum/carry = a + b + cin, captured on the clock edge.
// - Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, carry).
// - Leaf arithmetic block for datapaths and ALU slices; no handshake, result valid every cycle.
//

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_full_adder_bit.sv | 13 +
 rtl/adder.sv | 65 ++++++
 tb/tb_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared adder definitions: width limit and the {carry, sum} result record
// used by the adder and by ALU code that consumes its result.
package adder_pkg;

  localparam int unsigned ADDER_MAX_WIDTH = 64;

  typedef struct packed {
    logic                       carry;
    logic [ADDER_MAX_WIDTH-1:0] sum;
  } adder_result_t;

  function automatic adder_result_t adder_pack(input logic carry,
                                               input logic [ADDER_MAX_WIDTH-1:0] sum);
    adder_result_t r;
    r.carry = carry;
    r.sum   = sum;
    return r;
  endfunction

endpackage

// File: rtl/adder_full_adder_bit.sv
// One ripple stage: combinational 1-bit full adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder.sv
// Ripple-carry adder {carry, sum} = a + b + cin, optionally registered
// behind an async active-low reset.
module adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_width_check
    $error("adder: WIDTH out of range 1..%0d", ADDER_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign carry_d = c[WIDTH];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum   = sum_d;
    assign carry = carry_d;
  end

endmodule

// File: tb/tb_adder.sv
// Bench for adder: registered WIDTH=1 and WIDTH=8 builds plus a combinational WIDTH=4 build.
module tb_adder;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, ci1;
  logic       s1, c1;
  logic [7:0] a8, b8;
  logic       ci8;
  logic [7:0] s8;
  logic       c8;
  logic [3:0] a4, b4;
  logic       ci4;
  logic [3:0] s4;
  logic       c4;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  exp_t sb1[$];
  exp_t sb8[$];

  adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(ci1), .sum(s1), .carry(c1)
  );
  adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8), .sum(s8), .carry(c8)
  );
  adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(ci4), .sum(s4), .carry(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {carry,sum}=%h, expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int sel, input string name);
    exp_t e;
    if (sel == 1) begin
      if (sb1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL %s: scoreboard empty, got %b%b", name, c1, s1);
      end else begin
        e = sb1.pop_front();
        check(name, {1'b0, 6'd0, c1, s1}, {1'b0, 6'd0, e.carry, e.sum[0]});
      end
    end else begin
      if (sb8.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL %s: scoreboard empty, got %b_%h", name, c8, s8);
      end else begin
        e = sb8.pop_front();
        check(name, {c8, s8}, {e.carry, e.sum});
      end
    end
  endtask

  task automatic apply(input int sel, input vec_t v, input string name);
    @(negedge clk);
    if (sel == 1) begin
      a1 = v.a[0]; b1 = v.b[0]; ci1 = v.cin;
      sb1.push_back('{sum: v.sum, carry: v.carry});
    end else begin
      a8 = v.a; b8 = v.b; ci8 = v.cin;
      sb8.push_back('{sum: v.sum, carry: v.carry});
    end
    @(posedge clk);
    #1;
    pop_check(sel, name);
  endtask

  vec_t tt1[8];
  vec_t tt8[6];
  logic [4:0] exp4;

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Full-adder truth table, then 8-bit boundary and mixed cases.
    tt1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tt1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
    tt1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
    tt1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tt1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tt1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
    tt1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
    tt1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};

    tt8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tt8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tt8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tt8[3] = '{8'h3C, 8'h55, 1'b1, 8'h92, 1'b0};
    tt8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tt8[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1;

    // Reset state, held across clock edges.
    #22;
    check("reset_w1", {7'd0, c1, s1}, 9'd0);
    check("reset_w8", {c8, s8}, 9'd0);
    check("comb_in_reset", {4'd0, c4, s4}, 9'h012);

    // Release and capture on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
    sb1.push_back('{sum: 8'd1, carry: 1'b0});
    @(posedge clk);
    #1;
    pop_check(1, "first_after_reset");

    apply(1, '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1}, "w1_0p1p1");

    for (int unsigned i = 0; i < 8; i++) apply(1, tt1[i], $sformatf("w1_tt%0d", i));
    for (int unsigned i = 0; i < 6; i++) apply(8, tt8[i], $sformatf("w8_vec%0d", i));

    // Reset mid-stream: the in-flight result is discarded.
    apply(1, '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1}, "pre_midreset");
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
    sb1.push_back('{sum: 8'd0, carry: 1'b1});
    #2;
    rst_n = 1'b0;
    sb1.delete();
    #1;
    check("midreset_immediate", {7'd0, c1, s1}, 9'd0);
    @(posedge clk);
    #1;
    check("midreset_hold", {7'd0, c1, s1}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; ci1 = 1'b0;
    sb1.push_back('{sum: 8'd1, carry: 1'b0});
    #1;
    check("midreset_release_no_edge", {7'd0, c1, s1}, 9'd0);
    @(posedge clk);
    #1;
    pop_check(1, "midreset_release_edge");

    // Combinational build: result settles without any clock edge.
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      ci4 = 1'($urandom_range(0, 1));
      if (i == 0) begin a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; end
      if (i == 1) begin a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1; end
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, ci4};
      #1;
      check($sformatf("comb_w4_%0d", i), {4'd0, c4, s4}, {4'd0, exp4});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
